// File: rtl/scope_ctrl_panel.sv
// Front-panel controller: five buttons are synchronised, debounced and edge-pulsed, then drive the menu FSM.
// Optional auto-repeat on held up/down: define SCOPE_CTRL_AUTOREPEAT_EN.
module scope_ctrl_panel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TRIG_W          = 12,
  parameter int TRIG_STEP       = 16,
  parameter int TB_MAX          = 15,
  parameter int VS_MAX          = 7,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_center,
  output logic [TRIG_W-1:0] trig_level,
  output logic [3:0]        timebase,
  output logic [2:0]        vscale,
  output logic              run,
  output logic [1:0]        sel,
  output logic              cfg_update
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TRIG_W-1:0] STEP = TRIG_W'(TRIG_STEP);
  localparam logic [TRIG_W-1:0] TRIG_RST = {1'b1, {(TRIG_W-1){1'b0}}};

  typedef enum logic [1:0] {S_TRIG = 2'd0, S_TB = 2'd1, S_VS = 2'd2} sel_t;

  // Bit order of every per-button vector: 0 up, 1 down, 2 left, 3 right, 4 centre
  logic [4:0]      raw;
  logic [4:0]      sync_p0, sync_p1;
  logic [DB_W-1:0] db_cnt_p2 [5];
  logic [4:0]      deb_p2, deb_d_p3, pulse_p3, rpt_vec;

  sel_t              sel_q, sel_nxt;
  logic [TRIG_W-1:0] trig_q, trig_nxt;
  logic [3:0]        tb_q, tb_nxt, vs_wide;
  logic [2:0]        vs_q, vs_nxt;
  logic              run_q, run_nxt, upd_p4;

  function automatic logic [TRIG_W-1:0] trig_step(input logic [TRIG_W-1:0] cur, input logic inc);
    logic [TRIG_W:0] wide;
    if (inc) begin
      wide = {1'b0, cur} + {1'b0, STEP};
      return wide[TRIG_W] ? {TRIG_W{1'b1}} : wide[TRIG_W-1:0];
    end
    return (cur < STEP) ? '0 : cur - STEP;
  endfunction

  function automatic logic [3:0] idx_step(input logic [3:0] cur, input logic inc, input logic [3:0] max);
    if (inc) return (cur >= max) ? max : cur + 4'd1;
    return (cur == 4'd0) ? 4'd0 : cur - 4'd1;
  endfunction

  assign raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  // p0/p1: two-flop synchroniser
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // p2: debounce, level flips after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_p2 <= '0;
      for (int i = 0; i < 5; i++) db_cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          db_cnt_p2[i] <= '0;
        end else if (db_cnt_p2[i] == DB_LAST) begin
          db_cnt_p2[i] <= '0;
          deb_p2[i]    <= ~deb_p2[i];
        end else begin
          db_cnt_p2[i] <= db_cnt_p2[i] + 1'b1;
        end
      end
    end
  end

`ifdef SCOPE_CTRL_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_hold, rpt_fire;

  // Counter reloads so the next fire lands REPEAT_RATE cycles after the previous one
  assign rpt_hold = (deb_p2 == 5'b00001) || (deb_p2 == 5'b00010);
  assign rpt_fire = rpt_hold && (rpt_cnt == RPT_W'(REPEAT_DELAY));
  assign rpt_vec  = {3'b000, deb_p2[1:0] & {2{rpt_fire}}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      rpt_cnt <= '0;
    else if (!rpt_hold) rpt_cnt <= '0;
    else if (rpt_fire) rpt_cnt <= RPT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
    else               rpt_cnt <= rpt_cnt + 1'b1;
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rpt_vec = '0;
`endif

  // p3: single pulse per debounced rising edge (plus auto-repeat pulses)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_d_p3 <= '0;
      pulse_p3 <= '0;
    end else begin
      deb_d_p3 <= deb_p2;
      pulse_p3 <= (deb_p2 & ~deb_d_p3) | rpt_vec;
    end
  end

  // p4: menu state and configuration registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q  <= S_TRIG;
      trig_q <= TRIG_RST;
      tb_q   <= 4'd4;
      vs_q   <= 3'd2;
      run_q  <= 1'b1;
      upd_p4 <= 1'b0;
    end else begin
      sel_q  <= sel_nxt;
      trig_q <= trig_nxt;
      tb_q   <= tb_nxt;
      vs_q   <= vs_nxt;
      run_q  <= run_nxt;
      upd_p4 <= (sel_nxt != sel_q) || (trig_nxt != trig_q) || (tb_nxt != tb_q) ||
                (vs_nxt != vs_q) || (run_nxt != run_q);
    end
  end

  // Priority chain is the arbiter: centre > left > right > up > down, losers dropped
  always_comb begin
    sel_nxt  = sel_q;
    trig_nxt = trig_q;
    tb_nxt   = tb_q;
    vs_nxt   = vs_q;
    run_nxt  = run_q;
    vs_wide  = {1'b0, vs_q};
    if (pulse_p3[4]) begin
      run_nxt = ~run_q;
    end else if (pulse_p3[2]) begin
      case (sel_q)
        S_TRIG:  sel_nxt = S_VS;
        S_VS:    sel_nxt = S_TB;
        default: sel_nxt = S_TRIG;
      endcase
    end else if (pulse_p3[3]) begin
      case (sel_q)
        S_TRIG:  sel_nxt = S_TB;
        S_TB:    sel_nxt = S_VS;
        default: sel_nxt = S_TRIG;
      endcase
    end else if (pulse_p3[0] || pulse_p3[1]) begin
      case (sel_q)
        S_TRIG: trig_nxt = trig_step(trig_q, pulse_p3[0]);
        S_TB:   tb_nxt   = idx_step(tb_q, pulse_p3[0], 4'(TB_MAX));
        S_VS: begin
          vs_wide = idx_step({1'b0, vs_q}, pulse_p3[0], 4'(VS_MAX));
          vs_nxt  = vs_wide[2:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    trig_level = trig_q;
    timebase   = tb_q;
    vscale     = vs_q;
    run        = run_q;
    sel        = sel_q;
    cfg_update = upd_p4;
  end

endmodule

// File: tb/tb_scope_ctrl_panel.sv
// Scoreboard bench for scope_ctrl_panel: press events feed a behavioural menu model, a monitor checks every cycle.
module tb_scope_ctrl_panel;
  localparam int DB = 4, TW = 12, STEP = 16, TBM = 15, VSM = 7, RD = 20, RR = 5;
  localparam int LAT = DB + 4;
  localparam int TMAX = (1 << TW) - 1;
  localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LF = 5'b00100, RT = 5'b01000, CT = 5'b10000;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_center = 0;
  logic [TW-1:0] trig_level;
  logic [3:0] timebase;
  logic [2:0] vscale;
  logic run, cfg_update;
  logic [1:0] sel;

  scope_ctrl_panel #(.DEBOUNCE_CYCLES(DB), .TRIG_W(TW), .TRIG_STEP(STEP), .TB_MAX(TBM),
                     .VS_MAX(VSM), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clock(clock), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_center(btn_center),
    .trig_level(trig_level), .timebase(timebase), .vscale(vscale), .run(run),
    .sel(sel), .cfg_update(cfg_update));

  always #5 clock = ~clock;

  typedef struct { int t; int trig; int tb; int vs; int run; int sel; } exp_t;
  exp_t q[$];
  exp_t shadow;
  int cyc = 0;
  int vectors = 0, miscompares = 0;
  int m_trig, m_tb, m_vs, m_run, m_sel;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      if (miscompares < 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic chk_all(input exp_t e, input int upd);
    chk("trig_level", int'(trig_level), e.trig);
    chk("timebase", int'(timebase), e.tb);
    chk("vscale", int'(vscale), e.vs);
    chk("run", int'(run), e.run);
    chk("sel", int'(sel), e.sel);
    chk("cfg_update", int'(cfg_update), upd);
  endtask

  function automatic exp_t reset_state();
    exp_t e;
    e = '{t: 0, trig: 1 << (TW - 1), tb: 4, vs: 2, run: 1, sel: 0};
    return e;
  endfunction

  // Monitor: a queued entry due this cycle must appear with cfg_update; otherwise outputs hold
  always @(negedge clock) begin
    exp_t e;
    int upd;
    if (!reset_n) begin
      q.delete();
      shadow = reset_state();
      chk_all(shadow, 0);
    end else begin
      upd = 0;
      e = shadow;
      while (q.size() > 0 && q[0].t < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL late_update: change due at cycle %0d not seen by cycle %0d", q[0].t, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].t == cyc) begin
        e = q.pop_front();
        upd = 1;
      end
      chk_all(e, upd);
      shadow = e;
    end
  end

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    m_trig = 1 << (TW - 1); m_tb = 4; m_vs = 2; m_run = 1; m_sel = 0;
  endtask

  // Apply one accepted action to the menu model; enqueue only if something changed.
  task automatic act(input logic [4:0] mask, input int t);
    int o_trig, o_tb, o_vs, o_run, o_sel, d;
    exp_t e;
    o_trig = m_trig; o_tb = m_tb; o_vs = m_vs; o_run = m_run; o_sel = m_sel;
    if (mask[4]) m_run = 1 - m_run;
    else if (mask[2]) m_sel = (m_sel + 2) % 3;
    else if (mask[3]) m_sel = (m_sel + 1) % 3;
    else if (mask[0] || mask[1]) begin
      d = mask[0] ? 1 : -1;
      if (m_sel == 0) m_trig = clamp(m_trig + d * STEP, 0, TMAX);
      else if (m_sel == 1) m_tb = clamp(m_tb + d, 0, TBM);
      else m_vs = clamp(m_vs + d, 0, VSM);
    end
    if (m_trig != o_trig || m_tb != o_tb || m_vs != o_vs || m_run != o_run || m_sel != o_sel) begin
      e = '{t: t, trig: m_trig, tb: m_tb, vs: m_vs, run: m_run, sel: m_sel};
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    {btn_center, btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  // Raw buttons in mask held for 'hold' cycles; held at least DB cycles counts as a press.
  task automatic press(input logic [4:0] mask, input int hold, input int gap);
    int k;
    @(posedge clock); #1;
    k = cyc;
    drive(mask);
    if (hold >= DB) begin
      act(mask, k + LAT);
`ifdef SCOPE_CTRL_AUTOREPEAT_EN
      if (mask == UP || mask == DN)
        for (int j = 0; LAT + RD + RR * j <= hold + DB + 3; j++) act(mask, k + LAT + RD + RR * j);
`endif
    end
    repeat (hold) @(posedge clock);
    #1 drive(5'b0);
    repeat (gap) @(posedge clock);
  endtask

  initial begin
    int k;
    logic [4:0] m;
    model_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // idle after reset: no strobes, reset values hold
    repeat (50) @(posedge clock);

    // bounce then real press
    press(UP, DB - 1, 12);
    press(UP, 40, 12);

    // timebase walk to zero with saturating presses, then left twice
    press(RT, DB + 2, 10);
    repeat (10) press(DN, DB + 1, 10);
    press(LF, DB + 2, 10);
    press(LF, DB + 2, 10);

    // simultaneous centre and up: centre wins, up discarded
    press(CT | UP, 10, 12);
    press(UP, DB + 3, 12);

    // reset during a held press, button treated as new press afterwards
    @(posedge clock); #1;
    k = cyc;
    btn_up = 1'b1;
    act(UP, k + LAT);
    repeat (12) @(posedge clock);
    #1 reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    k = cyc;
    act(UP, k + LAT);
    repeat (20) @(posedge clock);
    #1 btn_up = 1'b0;
    repeat (12) @(posedge clock);

    // drive trigger level into its upper clamp
`ifdef SCOPE_CTRL_AUTOREPEAT_EN
    press(UP, 700, 12);
    press(UP, 60, 12);
`else
    repeat (130) press(UP, DB, 6);
`endif

    // randomized presses, bounces and simultaneous pairs
    for (int n = 0; n < 220; n++) begin
      m = 5'b1 << $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) m = m | (5'b1 << $urandom_range(0, 4));
      press(m, $urandom_range(1, 14), $urandom_range(DB + 4, DB + 10));
    end

    repeat (LAT + 6) @(posedge clock);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_updates: got %0d outstanding, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
